ifetch: RTL and testbench
=========================

IFETCH -- requirements
Module: ifetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, the first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, the number of prefetch buffer entries (power of two, at least 2).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port imem_addr, output, 32 bits: byte address to instruction memory; combinational copy of fetch_pc.
REQ-006 SHALL have port imem_instr, input, 32 bits: instruction word returned combinationally for imem_addr.
REQ-007 SHALL have port redirect_valid, input, 1 bit: branch/jump/trap redirect request.
REQ-008 SHALL have port redirect_pc, input, 32 bits: redirect target.
REQ-009 SHALL have port out_valid, output, 1 bit: a buffered instruction is available to decode.
REQ-010 SHALL have port out_ready, input, 1 bit: decode accepts the head entry.
REQ-011 SHALL have port out_instr, output, 32 bits: head-entry instruction.
REQ-012 SHALL have port out_pc, output, 32 bits: head-entry address.
REQ-013 SHALL have port fault, output, 1 bit: misaligned-redirect fault (see Configuration).

Function
REQ-014 SHALL define pop = out_valid && out_ready, and push = !redirect_valid && !halted && (!full || pop).
REQ-015 On push, SHALL write {fetch_pc, imem_instr} at the FIFO tail and set fetch_pc <= fetch_pc + 4 (mod 2^32; 32'hFFFFFFFC wraps to 32'h00000000).
REQ-016 On pop, SHALL advance the head; out_instr/out_pc SHALL hold stable while out_valid=1 and out_ready=0.
REQ-017 SHALL drive out_valid = !empty && !redirect_valid; out_instr/out_pc are don't-care when out_valid=0.
REQ-018 Simultaneous push and pop on a full FIFO SHALL keep occupancy unchanged and lose no entry.
REQ-019 On redirect_valid=1, SHALL at that edge empty the FIFO, perform no push, and set fetch_pc <= redirect_pc; redirect has priority over push and pop.
REQ-020 Latency: an instruction pushed at edge N SHALL show out_valid=1 after edge N; redirect at edge N SHALL produce the target instruction valid after edge N+1.
REQ-021 Without back-pressure, SHALL sustain one instruction per cycle.
REQ-022 A redirect on consecutive cycles SHALL take the last redirect_pc.

Reset
REQ-023 While rst_n=0, SHALL hold fetch_pc=RESET_PC, FIFO empty, out_valid=0, fault=0, halted=0, imem_addr=RESET_PC.
REQ-024 Assertion of rst_n mid-operation SHALL discard all buffered entries immediately; fetch SHALL begin at the first rising edge with rst_n=1.

Configuration
REQ-025 With IFETCH_MISALIGN_TRAP_EN defined, a redirect with redirect_pc[1:0]!=0 SHALL set fault=1 and halted=1 at that edge, with no pushes until a later aligned redirect clears both, or until reset.
REQ-026 Without IFETCH_MISALIGN_TRAP_EN, redirect_pc[1:0] SHALL be treated as 2'b00, fault SHALL be tied 0, and halted SHALL never assert.

Structure
REQ-027 Package ifetch_pkg SHALL hold XLEN=32, ILEN=32, INSN_NOP=32'h00000013 and the FIFO entry struct {pc, instr}.
REQ-028 SHALL instantiate one sub-module, ifetch_fifo: a synchronous FIFO with push, pop, flush, full and empty, reset by rst_n.

Verification
REQ-029 Reset release, imem holding sequential words, out_ready=1 -> out_pc sequence 0x0, 0x4, 0x8, one per cycle, out_instr matching memory.
REQ-030 out_ready=0 for 5 cycles -> FIFO fills to FIFO_DEPTH, imem_addr freezes at 0x8, head stable; ready=1 -> no loss or duplication.
REQ-031 Redirect to 0x100 while full with pop asserted -> buffered entries discarded, out_valid=0 that cycle, next valid out_pc=0x100 two edges later.
REQ-032 RESET_PC=32'hFFFFFFF8 -> out_pc sequence FFFFFFF8, FFFFFFFC, 00000000.
REQ-033 With macro: redirect to 0x102 -> fault=1, out_valid stays 0; redirect to 0x200 -> fault=0, fetch resumes at 0x200. Without macro: the same redirect to 0x102 -> fetch at 0x100, fault=0.
REQ-034 rst_n low mid-stream for 1 cycle -> out_valid=0 immediately; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifetch_pkg.sv
// ifetch_pkg -- shared types and constants for the instruction fetch unit.
//
// Contents:
//   XLEN, ILEN      address / instruction widths
//   INSN_NOP        canonical NOP (addi x0, x0, 0), driven on out_instr when idle
//   PC_STEP         sequential fetch increment
//   fifo_entry_t    prefetch buffer entry {pc, instr}
//   align_word()    clears the two low address bits
//   is_misaligned() true when the two low address bits are non-zero
package ifetch_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] INSN_NOP = 32'h00000013;
    localparam logic [XLEN-1:0] PC_STEP  = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fifo_entry_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo -- synchronous prefetch FIFO of fifo_entry_t records.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (pointers only)
//   push, wr_data   write wr_data at the tail
//   pop             advance the head
//   flush           empty the FIFO; overrides push and pop
//   rd_data         head entry (valid only while empty = 0)
//   full, empty     occupancy flags
//
// DEPTH must be a power of two, at least 2. A push on a full FIFO is
// accepted only together with a pop, in which case it lands in the slot the
// head is leaving, so occupancy stays unchanged.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  fifo_entry_t wr_data,
    output fifo_entry_t rd_data,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    fifo_entry_t mem_q [DEPTH];
    fifo_entry_t mem_d [DEPTH];
    logic do_push;
    logic do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);

    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q[AW-1:0]] = wr_data;
                wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is qualified by the pointers, so it needs no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/ifetch.sv
// ifetch -- instruction fetch unit with a small prefetch buffer.
//
// Parameters:
//   RESET_PC     first fetch address after reset
//   FIFO_DEPTH   prefetch entries (power of two, >= 2)
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   imem_addr  (out)                fetch address, copy of fetch_pc
//   imem_instr (in)                 instruction word for imem_addr (combinational)
//   redirect_valid, redirect_pc     redirect request; flushes the buffer
//   out_valid, out_ready            decode handshake on the head entry
//   out_instr, out_pc               head entry
//   fault                           misaligned-redirect fault
//
// Build option IFETCH_MISALIGN_TRAP_EN: when defined, a redirect to a
// non-word-aligned target raises fault and halts fetching until an aligned
// redirect or reset. When undefined, the low two target bits are ignored and
// fault is tied low.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h00000000,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] imem_addr,
    input  logic [ILEN-1:0] imem_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ILEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic            fault
);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            halted;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    fifo_entry_t     wr_entry;
    fifo_entry_t     head;

    // A redirect hides the head in the same cycle: whatever is buffered
    // belongs to the old path and is dropped at this edge.
    assign out_valid = !empty && !redirect_valid;
    assign pop       = out_valid && out_ready;
    assign push      = !redirect_valid && !halted && (!full || pop);

    assign wr_entry.pc    = fetch_pc_q;
    assign wr_entry.instr = imem_instr;

    assign out_pc    = head.pc;
    assign out_instr = out_valid ? head.instr : INSN_NOP;
    assign imem_addr = fetch_pc_q;

    ifetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .flush   (redirect_valid),
        .wr_data (wr_entry),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

`ifdef IFETCH_MISALIGN_TRAP_EN

    logic halted_q, halted_d;
    logic fault_q, fault_d;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        halted_d   = halted_q;
        fault_d    = fault_q;
        if (redirect_valid) begin
            // The raw target is kept; it is never fetched while halted.
            fetch_pc_d = redirect_pc;
            halted_d   = is_misaligned(redirect_pc);
            fault_d    = is_misaligned(redirect_pc);
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            halted_q   <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            halted_q   <= halted_d;
            fault_q    <= fault_d;
        end
    end

    assign halted = halted_q;
    assign fault  = fault_q;

`else

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = align_word(redirect_pc);
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    assign halted = 1'b0;
    assign fault  = 1'b0;

`endif

endmodule

// File: tb/tb_ifetch.sv
// Testbench for ifetch: directed vector table, hand sequences for reset,
// misaligned redirect and PC wrap, and a randomized run against a
// queue-based reference model.
module tb_ifetch;
    import ifetch_pkg::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: RESET_PC = 0
    logic        rst_n;
    logic [31:0] imem_addr, imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid, out_ready;
    logic [31:0] out_instr, out_pc;
    logic        fault;

    // Instance B: RESET_PC near the top of the address space
    logic        b_rst_n;
    logic [31:0] b_imem_addr, b_imem_instr;
    logic        b_redirect_valid;
    logic [31:0] b_redirect_pc;
    logic        b_out_valid, b_out_ready;
    logic [31:0] b_out_instr, b_out_pc;
    logic        b_fault;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h00000013;
    endfunction

    assign imem_instr   = mem_word(imem_addr);
    assign b_imem_instr = mem_word(b_imem_addr);

    ifetch #(.RESET_PC(32'h00000000), .FIFO_DEPTH(DEPTH)) dut_a (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .fault(fault)
    );

    ifetch #(.RESET_PC(32'hFFFFFFF8), .FIFO_DEPTH(DEPTH)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .imem_addr(b_imem_addr), .imem_instr(b_imem_instr),
        .redirect_valid(b_redirect_valid), .redirect_pc(b_redirect_pc),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_instr(b_out_instr),
        .out_pc(b_out_pc), .fault(b_fault)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rv, input logic [31:0] rpc, input logic rdy,
                                input logic ev, input logic [31:0] epc, input logic [31:0] ea);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.exp_valid = ev; v.exp_pc = epc; v.exp_addr = ea;
        return v;
    endfunction

    // Reference model state
    logic [31:0] mq[$];
    logic [31:0] mpc;
    logic        mhalt;
    logic        mfault;

    initial begin
        logic        exp_v;
        logic        rv, rdy;
        logic [31:0] rpc;
        logic        popped, was_full;

        // Sequential fetch, 5 cycles of back-pressure, then a redirect while full.
        vecs.push_back(mk(0, 0,     1, 0, 0,     32'h0));
        vecs.push_back(mk(0, 0,     1, 1, 32'h0, 32'h4));
        vecs.push_back(mk(0, 0,     1, 1, 32'h4, 32'h8));
        vecs.push_back(mk(0, 0,     0, 1, 32'h8, 32'hC));
        vecs.push_back(mk(0, 0,     0, 1, 32'h8, 32'h10));
        vecs.push_back(mk(0, 0,     0, 1, 32'h8, 32'h10));
        vecs.push_back(mk(0, 0,     0, 1, 32'h8, 32'h10));
        vecs.push_back(mk(0, 0,     0, 1, 32'h8, 32'h10));
        vecs.push_back(mk(0, 0,     1, 1, 32'h8, 32'h10));
        vecs.push_back(mk(0, 0,     1, 1, 32'hC, 32'h14));
        vecs.push_back(mk(0, 0,     0, 1, 32'h10, 32'h18));
        vecs.push_back(mk(1, 32'h100, 1, 0, 0,   32'h18));
        vecs.push_back(mk(0, 0,     1, 0, 0,     32'h100));
        vecs.push_back(mk(0, 0,     1, 1, 32'h100, 32'h104));
        vecs.push_back(mk(0, 0,     1, 1, 32'h104, 32'h108));

        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        b_rst_n = 1'b0; b_redirect_valid = 1'b0; b_redirect_pc = '0; b_out_ready = 1'b1;

        repeat (2) next_cycle();
        check_bit("reset_valid", out_valid, 1'b0);
        check("reset_addr", imem_addr, 32'h0);
        check_bit("reset_fault", fault, 1'b0);
        check("reset_b_addr", b_imem_addr, 32'hFFFFFFF8);
        check_bit("reset_b_valid", b_out_valid, 1'b0);

        rst_n = 1'b1;
        foreach (vecs[i]) begin
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            out_ready      = vecs[i].rdy;
            @(negedge clk);
            check_bit($sformatf("vec%0d_valid", i), out_valid, vecs[i].exp_valid);
            check($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d_pc", i), out_pc, vecs[i].exp_pc);
                check($sformatf("vec%0d_instr", i), out_instr, mem_word(vecs[i].exp_pc));
            end
            next_cycle();
        end

        // Mid-stream reset: buffer holds 0x108, fetch at 0x10C.
        redirect_valid = 1'b0; out_ready = 1'b1;
        #1;
        check_bit("midrst_pre_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check_bit("midrst_valid", out_valid, 1'b0);
        check("midrst_addr", imem_addr, 32'h0);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check_bit("midrst_rel_valid", out_valid, 1'b0);
        check("midrst_rel_addr", imem_addr, 32'h0);
        next_cycle();
        @(negedge clk);
        check_bit("midrst_first_valid", out_valid, 1'b1);
        check("midrst_first_pc", out_pc, 32'h0);
        next_cycle();

        // Misaligned redirect
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        @(negedge clk);
        check_bit("mis_redir_valid", out_valid, 1'b0);
        next_cycle();
        redirect_valid = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_bit("mis_fault", fault, 1'b1);
            check_bit("mis_halt_valid", out_valid, 1'b0);
            next_cycle();
        end
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        check_bit("mis_fault_hold", fault, 1'b1);
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        check_bit("mis_clear_fault", fault, 1'b0);
        check("mis_resume_addr", imem_addr, 32'h200);
        next_cycle();
        @(negedge clk);
        check_bit("mis_resume_valid", out_valid, 1'b1);
        check("mis_resume_pc", out_pc, 32'h200);
        next_cycle();
`else
        @(negedge clk);
        check_bit("mis_fault", fault, 1'b0);
        check("mis_aligned_addr", imem_addr, 32'h100);
        next_cycle();
        @(negedge clk);
        check_bit("mis_aligned_valid", out_valid, 1'b1);
        check("mis_aligned_pc", out_pc, 32'h100);
        check_bit("mis_fault_after", fault, 1'b0);
        next_cycle();
`endif

        // Randomized run against the reference model, from a fresh reset.
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        mq.delete(); mpc = 32'h0; mhalt = 1'b0; mfault = 1'b0;
        for (int c = 0; c < 600; c++) begin
            rv  = ($urandom_range(0, 9) == 0);
            rpc = $urandom & 32'h0000FFFC;
            if ($urandom_range(0, 3) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            rdy = ($urandom_range(0, 9) < 7);
            redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
            @(negedge clk);
            exp_v = (mq.size() > 0) && !rv;
            check_bit("rand_valid", out_valid, exp_v);
            if (exp_v) begin
                check("rand_pc", out_pc, mq[0]);
                check("rand_instr", out_instr, mem_word(mq[0]));
            end
            check_bit("rand_fault", fault, mfault);
            if (!mhalt) check("rand_addr", imem_addr, mpc);
            next_cycle();
            if (rv) begin
                mq.delete();
`ifdef IFETCH_MISALIGN_TRAP_EN
                mpc    = rpc;
                mhalt  = (rpc[1:0] != 2'b00);
                mfault = mhalt;
`else
                mpc = rpc & 32'hFFFFFFFC;
`endif
            end else begin
                popped   = exp_v && rdy;
                was_full = (mq.size() == DEPTH);
                if (popped) void'(mq.pop_front());
                if (!mhalt && (!was_full || popped)) begin
                    mq.push_back(mpc);
                    mpc = mpc + 32'd4;
                end
            end
        end

        // Address wrap on instance B
        b_rst_n = 1'b1;
        @(negedge clk);
        check_bit("wrap_c0_valid", b_out_valid, 1'b0);
        check("wrap_c0_addr", b_imem_addr, 32'hFFFFFFF8);
        next_cycle();
        @(negedge clk);
        check_bit("wrap_c1_valid", b_out_valid, 1'b1);
        check("wrap_c1_pc", b_out_pc, 32'hFFFFFFF8);
        next_cycle();
        @(negedge clk);
        check("wrap_c2_pc", b_out_pc, 32'hFFFFFFFC);
        check("wrap_c2_instr", b_out_instr, mem_word(32'hFFFFFFFC));
        next_cycle();
        @(negedge clk);
        check_bit("wrap_c3_valid", b_out_valid, 1'b1);
        check("wrap_c3_pc", b_out_pc, 32'h00000000);
        check("wrap_c3_instr", b_out_instr, mem_word(32'h00000000));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
